// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the forwarding-select encodings, the "operand unused" Tuse value,
// and the address part of a shadow record plus its bubble constant.
package hazard_unit_pkg;

  localparam int AW = 5;

  // Tuse value meaning the operand is never read by this instruction.
  localparam logic [2:0] TUSE_NONE = 3'd7;

  // D-stage operand source
  localparam logic [1:0] FWD_D_GRF = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;

  // E-stage ALU operand source
  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  // M-stage store-data source
  localparam logic FWD_M_REG = 1'b0;
  localparam logic FWD_M_W   = 1'b1;

  typedef struct packed {
    logic [AW-1:0] raddr0;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] waddr;
  } addr_rec_t;

  // A bubble reads and writes nothing; its tnew is zero as well.
  localparam addr_rec_t BUBBLE_ADDRS = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// Shadow record for one pipeline stage: register addresses plus Tnew.
// Latency: 1 cycle. Backpressure: none; bubble overrides the load.
// Ports: clk/rst_n; bubble loads BUBBLE_ADDRS with tnew 0; in_* is the
// record of the previous stage, out_* the stored record. With DEC set
// the stored tnew is the incoming tnew decremented, saturating at 0.
module hazard_stage_reg
  import hazard_unit_pkg::*;
#(
  parameter int TW  = 3,
  parameter bit DEC = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bubble,
  input  addr_rec_t     in_addrs,
  input  logic [TW-1:0] in_tnew,
  output addr_rec_t     out_addrs,
  output logic [TW-1:0] out_tnew
);

  logic [TW-1:0] tnew_nxt;

  // Tnew never wraps: a finished producer stays at 0 as it moves on.
  always_comb begin
    tnew_nxt = in_tnew;
    if (DEC && (in_tnew != '0)) tnew_nxt = in_tnew - TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addrs <= BUBBLE_ADDRS;
      out_tnew  <= '0;
    end else if (bubble) begin
      out_addrs <= BUBBLE_ADDRS;
      out_tnew  <= '0;
    end else begin
      out_addrs <= in_addrs;
      out_tnew  <= tnew_nxt;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: stall request and forward selects.
// Latency: stall/fwd are combinational; shadow records and stall_cnt 1 cycle.
// Backpressure: stall freezes PC and F/D and bubbles D/E; M and W never stop.
// Ports: d_* is the D-stage descriptor (read addrs, Tuse, write addr, Tnew);
// fwd_d*/fwd_e*/fwd_m1 pick operand sources per stage; stall_cnt counts
// stall cycles since reset, saturating.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int TW   = 3,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      d_raddr0,
  input  logic [4:0]      d_raddr1,
  input  logic [4:0]      d_waddr,
  input  logic [TW-1:0]   d_tuse0,
  input  logic [TW-1:0]   d_tuse1,
  input  logic [TW-1:0]   d_tnew,
  output logic            stall,
  output logic [1:0]      fwd_d0,
  output logic [1:0]      fwd_d1,
  output logic [1:0]      fwd_e0,
  output logic [1:0]      fwd_e1,
  output logic            fwd_m1,
  output logic [CNTW-1:0] stall_cnt
);

  addr_rec_t     d_addrs, e_addrs, m_in, m_addrs, w_in, w_addrs;
  logic [TW-1:0] e_tnew, m_tnew, w_tnew;

  assign d_addrs = '{raddr0: d_raddr0, raddr1: d_raddr1, waddr: d_waddr};
  // M keeps only rt (store data); W keeps only the destination.
  assign m_in    = '{raddr0: '0, raddr1: e_addrs.raddr1, waddr: e_addrs.waddr};
  assign w_in    = '{raddr0: '0, raddr1: '0, waddr: m_addrs.waddr};

  // Tnew is counted on E entry, so the D->E load does not decrement.
  hazard_stage_reg #(.TW(TW), .DEC(1'b0)) u_e_rec (
    .clk(clk), .rst_n(rst_n), .bubble(stall),
    .in_addrs(d_addrs), .in_tnew(d_tnew),
    .out_addrs(e_addrs), .out_tnew(e_tnew)
  );

  hazard_stage_reg #(.TW(TW), .DEC(1'b1)) u_m_rec (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .in_addrs(m_in), .in_tnew(e_tnew),
    .out_addrs(m_addrs), .out_tnew(m_tnew)
  );

  hazard_stage_reg #(.TW(TW), .DEC(1'b1)) u_w_rec (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .in_addrs(w_in), .in_tnew(m_tnew),
    .out_addrs(w_addrs), .out_tnew(w_tnew)
  );

  // Record fields that are always zero by construction.
  logic unused_rec_bits;
  assign unused_rec_bits = ^{m_addrs.raddr0, w_addrs.raddr0, w_addrs.raddr1};

  // $0 never matches, which also covers producers with waddr 0.
  function automatic logic must_wait(input logic [4:0] raddr, input logic [TW-1:0] tuse,
                                     input logic [4:0] waddr, input logic [TW-1:0] tnew);
    return (raddr != '0) && (raddr == waddr) && (tnew > tuse);
  endfunction

  function automatic logic can_fwd(input logic [4:0] raddr, input logic [4:0] waddr,
                                   input logic [TW-1:0] tnew);
    return (raddr != '0) && (raddr == waddr) && (tnew == '0);
  endfunction

  // W producers never stall: they are forwarded or written through the GRF.
  assign stall = must_wait(d_raddr0, d_tuse0, e_addrs.waddr, e_tnew)
               | must_wait(d_raddr0, d_tuse0, m_addrs.waddr, m_tnew)
               | must_wait(d_raddr1, d_tuse1, e_addrs.waddr, e_tnew)
               | must_wait(d_raddr1, d_tuse1, m_addrs.waddr, m_tnew);

  // Youngest ready producer wins in every stage.
  always_comb begin
    fwd_d0 = FWD_D_GRF;
    if (can_fwd(d_raddr0, e_addrs.waddr, e_tnew))      fwd_d0 = FWD_D_E;
    else if (can_fwd(d_raddr0, m_addrs.waddr, m_tnew)) fwd_d0 = FWD_D_M;

    fwd_d1 = FWD_D_GRF;
    if (can_fwd(d_raddr1, e_addrs.waddr, e_tnew))      fwd_d1 = FWD_D_E;
    else if (can_fwd(d_raddr1, m_addrs.waddr, m_tnew)) fwd_d1 = FWD_D_M;

    fwd_e0 = FWD_E_REG;
    if (can_fwd(e_addrs.raddr0, m_addrs.waddr, m_tnew))      fwd_e0 = FWD_E_M;
    else if (can_fwd(e_addrs.raddr0, w_addrs.waddr, w_tnew)) fwd_e0 = FWD_E_W;

    fwd_e1 = FWD_E_REG;
    if (can_fwd(e_addrs.raddr1, m_addrs.waddr, m_tnew))      fwd_e1 = FWD_E_M;
    else if (can_fwd(e_addrs.raddr1, w_addrs.waddr, w_tnew)) fwd_e1 = FWD_E_W;

    fwd_m1 = FWD_M_REG;
    if (can_fwd(m_addrs.raddr1, w_addrs.waddr, w_tnew)) fwd_m1 = FWD_M_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: cycle table of descriptors with expected outputs,
// followed by a hand-written reset-during-stall sequence.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  d_raddr0, d_raddr1, d_waddr;
  logic [2:0]  d_tuse0, d_tuse1, d_tnew;
  logic        stall;
  logic [1:0]  fwd_d0, fwd_d1, fwd_e0, fwd_e1;
  logic        fwd_m1;
  logic [31:0] stall_cnt;

  hazard_unit #(.TW(3), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_raddr0(d_raddr0), .d_raddr1(d_raddr1), .d_waddr(d_waddr),
    .d_tuse0(d_tuse0), .d_tuse1(d_tuse1), .d_tnew(d_tnew),
    .stall(stall), .fwd_d0(fwd_d0), .fwd_d1(fwd_d1),
    .fwd_e0(fwd_e0), .fwd_e1(fwd_e1), .fwd_m1(fwd_m1),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [4:0] ra0, ra1, wa;
    logic [2:0] tu0, tu1, tn;
    logic       st;
    logic [1:0] fd0, fd1, fe0, fe1;
    logic       fm1;
    int         cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(string nm, int ra0, int ra1, int wa, int tu0, int tu1, int tn,
                              int st, int fd0, int fd1, int fe0, int fe1, int fm1, int cnt);
    vec_t v;
    v.nm = nm;  v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.wa = 5'(wa);
    v.tu0 = 3'(tu0); v.tu1 = 3'(tu1); v.tn = 3'(tn);
    v.st = 1'(st); v.fd0 = 2'(fd0); v.fd1 = 2'(fd1);
    v.fe0 = 2'(fe0); v.fe1 = 2'(fe1); v.fm1 = 1'(fm1); v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t nop(int fe0, int fe1, int fm1, int cnt);
    return mk("nop", 0, 0, 0, int'(TUSE_NONE), int'(TUSE_NONE), 0, 0, 0, 0, fe0, fe1, fm1, cnt);
  endfunction

  task automatic drive(input vec_t v);
    d_raddr0 = v.ra0; d_raddr1 = v.ra1; d_waddr = v.wa;
    d_tuse0  = v.tu0; d_tuse1  = v.tu1; d_tnew  = v.tn;
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    if (act != req) begin
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
      n_miss++;
    end
  endtask

  // Pops the oldest expectation and checks the outputs visible right now.
  task automatic check_now();
    vec_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard empty at vector %0d", n_vec);
      n_miss++;
      return;
    end
    e = exp_q.pop_front();
    cmp(e.nm, "stall", int'(stall), int'(e.st));
    // fwd_d is don't-care while stalling.
    if (!e.st) begin
      cmp(e.nm, "fwd_d0", int'(fwd_d0), int'(e.fd0));
      cmp(e.nm, "fwd_d1", int'(fwd_d1), int'(e.fd1));
    end
    cmp(e.nm, "fwd_e0", int'(fwd_e0), int'(e.fe0));
    cmp(e.nm, "fwd_e1", int'(fwd_e1), int'(e.fe1));
    cmp(e.nm, "fwd_m1", int'(fwd_m1), int'(e.fm1));
    cmp(e.nm, "stall_cnt", int'(stall_cnt), e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //          name          ra0 ra1 wa tu0 tu1 tn   st fd0 fd1 fe0 fe1 fm1 cnt
    tbl.push_back(nop(0, 0, 0, 0));
    // lw $8 then addu using $8 (tuse 1): one stall, then W->E forward
    tbl.push_back(mk("A_lw",       0,  0, 8, 1, 7, 2,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("A_stall",    8,  0, 11, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("A_go",       8,  0, 11, 1, 1, 1,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(2, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 1));
    // addu $9 then beq $9 (tuse 0): one stall, then M->D forward
    tbl.push_back(mk("B_addu",     0,  0, 9, 1, 1, 1,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("B_stall",    9,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("B_fwd",      9,  0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0, 2));
    tbl.push_back(nop(2, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    // lui $10 then sw $10: no stall, E->D, then M->E, then W->M
    tbl.push_back(mk("C_lui",      0,  0, 10, 7, 7, 0,  0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("C_sw",       0, 10, 0, 1, 2, 0,   0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(nop(0, 1, 0, 2));
    tbl.push_back(nop(0, 0, 1, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    // writer of $0, reader of $0, then tuse=7 on a pending producer
    tbl.push_back(mk("D_lw0",      0,  0, 0, 1, 7, 2,   0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("D_use0",     0,  0, 13, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("D_tnone",   13,  0, 0, 7, 7, 0,   0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(nop(1, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    // $12 ready in both E and M: E wins
    tbl.push_back(mk("E_lui_a",    0,  0, 12, 7, 7, 0,  0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("E_lui_b",    0,  0, 12, 7, 7, 0,  0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("E_read",    12, 12, 0, 1, 1, 0,   0, 1, 1, 0, 0, 0, 2));
    tbl.push_back(nop(1, 1, 0, 2));
    tbl.push_back(nop(0, 0, 1, 2));
    tbl.push_back(nop(0, 0, 0, 2));
    // lw-use stall that the reset sequence below interrupts
    tbl.push_back(mk("F_lw",       0,  0, 8, 1, 7, 2,   0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("F_stall",    8,  0, 14, 0, 0, 1,  1, 0, 0, 0, 0, 0, 2));

    rst_n = 1'b0;
    drive(nop(0, 0, 0, 0));
    #12;
    exp_q.push_back(mk("reset", 0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    check_now();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      check_now();
    end

    // Reset mid-stall: stall drops at once, counter and records clear.
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk("R_assert", 8, 0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    check_now();
    @(posedge clk);
    #1;
    exp_q.push_back(mk("R_hold", 8, 0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(mk("R_release", 8, 0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    check_now();
    @(posedge clk);
    #1;
    drive(nop(0, 0, 0, 0));
    exp_q.push_back(mk("R_first", 0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_now();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
